// File: rtl/rr_arbiter_2x1.sv
// rr_arbiter_2x1: burst-limited round-robin drain of two class FIFOs
// (FIFO #0 = class 0, FIFO #1 = class 1) into one downstream FIFO.
// Pops are combinational. Push and data are registered one cycle later.
module rr_arbiter_2x1 #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fifo0_empty,
  input  logic              fifo1_empty,
  input  logic [DATA_W-1:0] fifo0_data,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              out_almost_full,
  output logic              pop_0,
  output logic              pop_1,
  output logic              push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant
);

  // The encoding doubles as the one-hot grant: 00 idle, 01 serve 0, 10 serve 1.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_t     state, state_n;
  logic [3:0] burst_cnt, burst_cnt_n;
  logic       last_grant, last_grant_n;

  assign grant = state;

  // Pops: only while serving, enabled, the head is valid and downstream has room.
  always_comb begin
    pop_0 = en & (state == SERVE0) & ~fifo0_empty & ~out_almost_full;
    pop_1 = en & (state == SERVE1) & ~fifo1_empty & ~out_almost_full;
  end

  // Next-state, burst counter and round-robin pointer.
  always_comb begin
    state_n      = state;
    burst_cnt_n  = burst_cnt;
    last_grant_n = last_grant;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (!fifo0_empty && !fifo1_empty) begin
            state_n      = last_grant ? SERVE0 : SERVE1;
            burst_cnt_n  = '0;
            last_grant_n = ~last_grant;
          end else if (!fifo0_empty) begin
            state_n      = SERVE0;
            burst_cnt_n  = '0;
            last_grant_n = 1'b0;
          end else if (!fifo1_empty) begin
            state_n      = SERVE1;
            burst_cnt_n  = '0;
            last_grant_n = 1'b1;
          end
        end
        SERVE0: begin
          if (fifo0_empty || (pop_0 && burst_cnt == LAST_BEAT)) begin
            burst_cnt_n = '0;
            if (!fifo1_empty) begin
              state_n      = SERVE1;
              last_grant_n = 1'b1;
            end else if (fifo0_empty) begin
              state_n = IDLE;
            end
          end else begin
            burst_cnt_n = burst_cnt + {3'b000, pop_0};
          end
        end
        SERVE1: begin
          if (fifo1_empty || (pop_1 && burst_cnt == LAST_BEAT)) begin
            burst_cnt_n = '0;
            if (!fifo0_empty) begin
              state_n      = SERVE0;
              last_grant_n = 1'b0;
            end else if (fifo1_empty) begin
              state_n = IDLE;
            end
          end else begin
            burst_cnt_n = burst_cnt + {3'b000, pop_1};
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Control state register; last_grant resets to 1 so FIFO #0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      burst_cnt  <= burst_cnt_n;
      last_grant <= last_grant_n;
    end
  end

  // Output register: push follows any pop; data holds when nothing is popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_out <= 1'b0;
      data_out <= '0;
    end else begin
      push_out <= pop_0 | pop_1;
      if (pop_0)      data_out <= fifo0_data;
      else if (pop_1) data_out <= fifo1_data;
    end
  end

endmodule
